// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared widths, tag encodings and CDB snoop helper for the ALU reservation station
package alu_rs_pkg;

  localparam int RS_SIZE = 16;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int ROOT_W  = 4;
  localparam int OP_W    = 6;
  localparam int NAME_W  = 5;
  localparam int ADDR_W  = 32;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [ROOT_W-1:0] root_t;
  typedef logic [OP_W-1:0]   op_t;
  typedef logic [NAME_W-1:0] name_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Tag 0 marks valid data, so ALU tags carry prefix 1 to keep root 0 distinct from it.
  localparam tag_t TAG_FREE   = 5'h00;
  localparam logic ALU_PREFIX = 1'b1;
  localparam op_t  NOP        = 6'h00;

  typedef struct packed {
    tag_t  tag;
    data_t data;
  } opnd_t;

  // ALU bus checked first so it wins when both buses carry the same tag.
  function automatic opnd_t wake(opnd_t o, logic alu_en, tag_t alu_tag, data_t alu_data,
                                 logic ls_en, tag_t ls_tag, data_t ls_data);
    opnd_t r;
    r = o;
    if (o.tag != TAG_FREE) begin
      if (alu_en && alu_tag == o.tag) begin
        r.tag  = TAG_FREE;
        r.data = alu_data;
      end else if (ls_en && ls_tag == o.tag) begin
        r.tag  = TAG_FREE;
        r.data = ls_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, CDB snoop and issue signals of the ALU reservation station
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic    inEn;
  op_t     inOp;
  data_t   inOpndO, inOpndT;
  tag_t    inTagO, inTagT, inTagW;
  name_t   inNameW;
  addr_t   inAddr;

  logic    cdbAluEn, cdbLsEn;
  tag_t    cdbAluTag, cdbLsTag;
  data_t   cdbAluData, cdbLsData;

  logic [RS_SIZE-1:0] freeStatus;

  logic    exEn;
  op_t     exOp;
  data_t   exOpndO, exOpndT;
  tag_t    exTagW;
  name_t   exNameW;
  addr_t   exAddr;

  modport master (
    output inEn, inOp, inOpndO, inOpndT, inTagO, inTagT, inTagW, inNameW, inAddr,
    output cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData,
    input  freeStatus, exEn, exOp, exOpndO, exOpndT, exTagW, exNameW, exAddr
  );

  modport slave (
    input  inEn, inOp, inOpndO, inOpndT, inTagO, inTagT, inTagW, inNameW, inAddr,
    input  cdbAluEn, cdbAluTag, cdbAluData, cdbLsEn, cdbLsTag, cdbLsData,
    output freeStatus, exEn, exOp, exOpndO, exOpndT, exTagW, exNameW, exAddr
  );

endinterface

// File: rtl/rs_prio_enc.sv
// rtl/rs_prio_enc.sv - lowest-set-bit priority encoder shared by the reservation stations and free-tag table
module rs_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station: buffers dispatched ops, snoops both CDBs, issues lowest ready entry
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  alu_rs_if.slave bus
);

  logic [RS_SIZE-1:0] busy;
  op_t    op_q    [RS_SIZE];
  opnd_t  opnd_o  [RS_SIZE];
  opnd_t  opnd_t_q[RS_SIZE];
  tag_t   tag_w   [RS_SIZE];
  name_t  name_w  [RS_SIZE];
  addr_t  addr_q  [RS_SIZE];

  opnd_t  wk_o [RS_SIZE];
  opnd_t  wk_t [RS_SIZE];
  opnd_t  in_o, in_t;
  logic [RS_SIZE-1:0] ready;
  root_t  iss_idx;
  logic   iss_valid;
  root_t  alloc_idx;
  logic   alloc_ok;

  assign bus.freeStatus = ~busy;
  assign alloc_idx      = bus.inTagW[ROOT_W-1:0];
  assign alloc_ok       = bus.inEn && !busy[alloc_idx];

  // Incoming operands pass through the same snoop so a same-cycle broadcast is not lost.
  assign in_o = wake('{tag: bus.inTagO, data: bus.inOpndO}, bus.cdbAluEn, bus.cdbAluTag,
                     bus.cdbAluData, bus.cdbLsEn, bus.cdbLsTag, bus.cdbLsData);
  assign in_t = wake('{tag: bus.inTagT, data: bus.inOpndT}, bus.cdbAluEn, bus.cdbAluTag,
                     bus.cdbAluData, bus.cdbLsEn, bus.cdbLsTag, bus.cdbLsData);

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wk_o[i]  = wake(opnd_o[i], bus.cdbAluEn, bus.cdbAluTag, bus.cdbAluData,
                      bus.cdbLsEn, bus.cdbLsTag, bus.cdbLsData);
      wk_t[i]  = wake(opnd_t_q[i], bus.cdbAluEn, bus.cdbAluTag, bus.cdbAluData,
                      bus.cdbLsEn, bus.cdbLsTag, bus.cdbLsData);
      ready[i] = busy[i] && opnd_o[i].tag == TAG_FREE && opnd_t_q[i].tag == TAG_FREE;
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .W(ROOT_W)) u_enc (
    .req  (ready),
    .idx  (iss_idx),
    .valid(iss_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      bus.exEn    <= 1'b0;
      bus.exOp    <= NOP;
      bus.exOpndO <= '0;
      bus.exOpndT <= '0;
      bus.exTagW  <= TAG_FREE;
      bus.exNameW <= '0;
      bus.exAddr  <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          opnd_o[i]   <= wk_o[i];
          opnd_t_q[i] <= wk_t[i];
        end
        if (iss_valid && iss_idx == ROOT_W'(i)) busy[i] <= 1'b0;
      end

      // The allocated index is never busy, so it cannot collide with wakeup or issue.
      if (alloc_ok) begin
        busy[alloc_idx]     <= 1'b1;
        op_q[alloc_idx]     <= bus.inOp;
        opnd_o[alloc_idx]   <= in_o;
        opnd_t_q[alloc_idx] <= in_t;
        tag_w[alloc_idx]    <= bus.inTagW;
        name_w[alloc_idx]   <= bus.inNameW;
        addr_q[alloc_idx]   <= bus.inAddr;
      end

      bus.exEn <= iss_valid;
      if (iss_valid) begin
        bus.exOp    <= op_q[iss_idx];
        bus.exOpndO <= opnd_o[iss_idx].data;
        bus.exOpndT <= opnd_t_q[iss_idx].data;
        bus.exTagW  <= tag_w[iss_idx];
        bus.exNameW <= name_w[iss_idx];
        bus.exAddr  <= addr_q[iss_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - randomized self-checking bench for alu_rs with a transaction-level station model
module tb_alu_rs;

  localparam logic [4:0] FREE = 5'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  alu_rs_if bus();

  alu_rs dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.inEn)
      assert (bus.freeStatus[bus.inTagW[3:0]])
      else $error("FAIL illegal_dispatch index %0d is busy", bus.inTagW[3:0]);
  end

  // Station model: one record per slot, tag==FREE meaning the data is present.
  logic        m_busy [16];
  logic [4:0]  m_to [16], m_tt [16], m_tw [16], m_name [16];
  logic [31:0] m_do [16], m_dt [16], m_addr [16];
  logic [5:0]  m_op [16];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.inEn = 1'b0; bus.inOp = '0; bus.inOpndO = '0; bus.inOpndT = '0;
    bus.inTagO = FREE; bus.inTagT = FREE; bus.inTagW = FREE; bus.inNameW = '0; bus.inAddr = '0;
    bus.cdbAluEn = 1'b0; bus.cdbAluTag = FREE; bus.cdbAluData = '0;
    bus.cdbLsEn = 1'b0; bus.cdbLsTag = FREE; bus.cdbLsData = '0;
  endtask

  task automatic disp(input logic [3:0] root, input logic [4:0] to, input logic [4:0] tt,
                      input logic [31:0] d_o, input logic [31:0] d_t);
    bus.inEn = 1'b1; bus.inOp = {2'b01, root}; bus.inTagW = {1'b1, root};
    bus.inTagO = to; bus.inTagT = tt; bus.inOpndO = d_o; bus.inOpndT = d_t;
    bus.inNameW = {1'b0, root}; bus.inAddr = 32'h1000 + {26'd0, root, 2'b00};
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      disp(4'(i + 4), 5'h1F, FREE, 32'd0, 32'd0);
      step;
    end
    drive_idle;
    tests++;
    if (bus.freeStatus !== 16'hFF8F) begin
      fails++; $display("FAIL reset_pre_busy freeStatus=%h expected=%h", bus.freeStatus, 16'hFF8F);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    tests++;
    if (bus.freeStatus !== 16'hFFFF || bus.exEn !== 1'b0) begin
      fails++; $display("FAIL reset_state freeStatus=%h exEn=%b expected FFFF/0", bus.freeStatus, bus.exEn);
    end
    tests++;
    if (bus.exOp !== 6'h00 || bus.exOpndO !== 32'd0 || bus.exTagW !== FREE) begin
      fails++; $display("FAIL reset_ex exOp=%h exOpndO=%h exTagW=%h expected 0/0/0", bus.exOp, bus.exOpndO, bus.exTagW);
    end
    step;
    tests++;
    if (bus.exEn !== 1'b0) begin
      fails++; $display("FAIL reset_no_issue exEn=%b expected 0", bus.exEn);
    end
  endtask

  task automatic test_ready_dispatch;
    disp(4'd3, FREE, FREE, 32'd5, 32'd7);
    step;
    drive_idle;
    tests++;
    if (bus.freeStatus[3] !== 1'b0 || bus.exEn !== 1'b0) begin
      fails++; $display("FAIL ready_alloc free3=%b exEn=%b expected 0/0", bus.freeStatus[3], bus.exEn);
    end
    step;
    tests++;
    if (bus.exEn !== 1'b1 || bus.exOpndO !== 32'd5 || bus.exOpndT !== 32'd7 || bus.exTagW !== 5'h13) begin
      fails++; $display("FAIL ready_issue exEn=%b o=%0d t=%0d tagW=%h expected 1/5/7/13",
                        bus.exEn, bus.exOpndO, bus.exOpndT, bus.exTagW);
    end
    tests++;
    if (bus.freeStatus !== 16'hFFFF) begin
      fails++; $display("FAIL ready_freed freeStatus=%h expected FFFF", bus.freeStatus);
    end
    step;
    tests++;
    if (bus.exEn !== 1'b0) begin
      fails++; $display("FAIL ready_single exEn=%b expected 0", bus.exEn);
    end
  endtask

  task automatic test_wakeup;
    disp(4'd0, 5'h12, FREE, 32'd0, 32'd3);
    step;
    drive_idle;
    for (int i = 0; i < 4; i++) begin
      step;
      tests++;
      if (bus.exEn !== 1'b0) begin
        fails++; $display("FAIL wakeup_early cycle %0d exEn=%b expected 0", i, bus.exEn);
      end
    end
    bus.cdbLsEn = 1'b1; bus.cdbLsTag = 5'h12; bus.cdbLsData = 32'hDEAD;
    step;
    drive_idle;
    tests++;
    if (bus.exEn !== 1'b0) begin
      fails++; $display("FAIL wakeup_same_edge exEn=%b expected 0", bus.exEn);
    end
    step;
    tests++;
    if (bus.exEn !== 1'b1 || bus.exOpndO !== 32'hDEAD || bus.exOpndT !== 32'd3) begin
      fails++; $display("FAIL wakeup_issue exEn=%b o=%h t=%h expected 1/DEAD/3", bus.exEn, bus.exOpndO, bus.exOpndT);
    end
    step;
  endtask

  task automatic test_bypass;
    disp(4'd5, 5'h04, FREE, 32'd0, 32'd8);
    bus.cdbAluEn = 1'b1; bus.cdbAluTag = 5'h04; bus.cdbAluData = 32'd99;
    step;
    drive_idle;
    step;
    tests++;
    if (bus.exEn !== 1'b1 || bus.exOpndO !== 32'd99 || bus.exTagW !== 5'h15) begin
      fails++; $display("FAIL bypass exEn=%b o=%0d tagW=%h expected 1/99/15", bus.exEn, bus.exOpndO, bus.exTagW);
    end
    step;
  endtask

  task automatic test_priority_full;
    for (int i = 0; i < 16; i++) begin
      disp(4'(i), 5'h10 | 5'(i), FREE, 32'd0, 32'(i));
      step;
    end
    drive_idle;
    tests++;
    if (bus.freeStatus !== 16'h0000 || bus.exEn !== 1'b0) begin
      fails++; $display("FAIL full freeStatus=%h exEn=%b expected 0000/0", bus.freeStatus, bus.exEn);
    end
    bus.cdbAluEn = 1'b1; bus.cdbAluTag = 5'h19; bus.cdbAluData = 32'hAA;
    bus.cdbLsEn  = 1'b1; bus.cdbLsTag  = 5'h12; bus.cdbLsData  = 32'hBB;
    step;
    drive_idle;
    step;
    tests++;
    if (bus.exEn !== 1'b1 || bus.exTagW !== 5'h12 || bus.exOpndO !== 32'hBB || bus.freeStatus !== 16'h0004) begin
      fails++; $display("FAIL prio_first exEn=%b tagW=%h o=%h free=%h expected 1/12/BB/0004",
                        bus.exEn, bus.exTagW, bus.exOpndO, bus.freeStatus);
    end
    step;
    tests++;
    if (bus.exEn !== 1'b1 || bus.exTagW !== 5'h19 || bus.exOpndO !== 32'hAA || bus.freeStatus !== 16'h0204) begin
      fails++; $display("FAIL prio_second exEn=%b tagW=%h o=%h free=%h expected 1/19/AA/0204",
                        bus.exEn, bus.exTagW, bus.exOpndO, bus.freeStatus);
    end
    step;
    tests++;
    if (bus.exEn !== 1'b0) begin
      fails++; $display("FAIL prio_drained exEn=%b expected 0", bus.exEn);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
  endtask

  task automatic test_dual_cdb;
    disp(4'd7, FREE, 5'h07, 32'd11, 32'd0);
    step;
    drive_idle;
    bus.cdbAluEn = 1'b1; bus.cdbAluTag = 5'h07; bus.cdbAluData = 32'd1;
    bus.cdbLsEn  = 1'b1; bus.cdbLsTag  = 5'h07; bus.cdbLsData  = 32'd2;
    step;
    drive_idle;
    step;
    tests++;
    if (bus.exEn !== 1'b1 || bus.exOpndT !== 32'd1 || bus.exOpndO !== 32'd11) begin
      fails++; $display("FAIL dual_cdb exEn=%b t=%0d o=%0d expected 1/1/11", bus.exEn, bus.exOpndT, bus.exOpndO);
    end
    step;
  endtask

  task automatic test_random;
    int nfree, pick, e_idx, k;
    logic e_valid;
    logic [15:0] e_free;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_idle;
      bus.cdbAluEn = 1'($urandom_range(0, 1)); bus.cdbAluTag = 5'($urandom_range(1, 7)); bus.cdbAluData = $urandom;
      bus.cdbLsEn  = 1'($urandom_range(0, 1)); bus.cdbLsTag  = 5'($urandom_range(1, 7)); bus.cdbLsData  = $urandom;
      nfree = 0;
      for (int i = 0; i < 16; i++) if (!m_busy[i]) nfree++;
      if (nfree > 0 && $urandom_range(0, 2) != 0) begin
        pick = $urandom_range(0, nfree - 1);
        k = 0;
        for (int i = 0; i < 16; i++) begin
          if (!m_busy[i]) begin
            if (k == pick) begin
              bus.inEn = 1'b1; bus.inTagW = {1'b1, 4'(i)};
            end
            k++;
          end
        end
        bus.inOp = 6'($urandom); bus.inNameW = 5'($urandom); bus.inAddr = $urandom;
        bus.inOpndO = $urandom; bus.inOpndT = $urandom;
        bus.inTagO = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : FREE;
        bus.inTagT = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : FREE;
      end
      e_valid = 1'b0; e_idx = 0;
      for (int i = 15; i >= 0; i--)
        if (m_busy[i] && m_to[i] == FREE && m_tt[i] == FREE) begin e_valid = 1'b1; e_idx = i; end
      step;
      tests++;
      if (bus.exEn !== e_valid) begin
        fails++; $display("FAIL rand_exEn cyc %0d got %b expected %b", cyc, bus.exEn, e_valid);
      end
      if (e_valid) begin
        tests++;
        if ({bus.exOp, bus.exOpndO, bus.exOpndT, bus.exTagW, bus.exNameW, bus.exAddr} !==
            {m_op[e_idx], m_do[e_idx], m_dt[e_idx], m_tw[e_idx], m_name[e_idx], m_addr[e_idx]}) begin
          fails++; $display("FAIL rand_issue cyc %0d op=%h o=%h t=%h tagW=%h expected op=%h o=%h t=%h tagW=%h",
                            cyc, bus.exOp, bus.exOpndO, bus.exOpndT, bus.exTagW,
                            m_op[e_idx], m_do[e_idx], m_dt[e_idx], m_tw[e_idx]);
        end
        m_busy[e_idx] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        if (m_busy[i]) begin
          if (m_to[i] != FREE) begin
            if (bus.cdbAluEn && bus.cdbAluTag == m_to[i]) begin m_do[i] = bus.cdbAluData; m_to[i] = FREE; end
            else if (bus.cdbLsEn && bus.cdbLsTag == m_to[i]) begin m_do[i] = bus.cdbLsData; m_to[i] = FREE; end
          end
          if (m_tt[i] != FREE) begin
            if (bus.cdbAluEn && bus.cdbAluTag == m_tt[i]) begin m_dt[i] = bus.cdbAluData; m_tt[i] = FREE; end
            else if (bus.cdbLsEn && bus.cdbLsTag == m_tt[i]) begin m_dt[i] = bus.cdbLsData; m_tt[i] = FREE; end
          end
        end
      end
      if (bus.inEn) begin
        k = int'(bus.inTagW[3:0]);
        m_busy[k] = 1'b1; m_op[k] = bus.inOp; m_tw[k] = bus.inTagW; m_name[k] = bus.inNameW; m_addr[k] = bus.inAddr;
        m_to[k] = bus.inTagO; m_do[k] = bus.inOpndO; m_tt[k] = bus.inTagT; m_dt[k] = bus.inOpndT;
        if (m_to[k] != FREE) begin
          if (bus.cdbAluEn && bus.cdbAluTag == m_to[k]) begin m_do[k] = bus.cdbAluData; m_to[k] = FREE; end
          else if (bus.cdbLsEn && bus.cdbLsTag == m_to[k]) begin m_do[k] = bus.cdbLsData; m_to[k] = FREE; end
        end
        if (m_tt[k] != FREE) begin
          if (bus.cdbAluEn && bus.cdbAluTag == m_tt[k]) begin m_dt[k] = bus.cdbAluData; m_tt[k] = FREE; end
          else if (bus.cdbLsEn && bus.cdbLsTag == m_tt[k]) begin m_dt[k] = bus.cdbLsData; m_tt[k] = FREE; end
        end
      end
      for (int i = 0; i < 16; i++) e_free[i] = !m_busy[i];
      tests++;
      if (bus.freeStatus !== e_free) begin
        fails++; $display("FAIL rand_free cyc %0d got %h expected %h", cyc, bus.freeStatus, e_free);
      end
    end
    drive_idle;
    rst = 1'b1;
    step;
    rst = 1'b0;
    tests++;
    if (bus.freeStatus !== 16'hFFFF || bus.exEn !== 1'b0) begin
      fails++; $display("FAIL rand_final_reset free=%h exEn=%b expected FFFF/0", bus.freeStatus, bus.exEn);
    end
  endtask

  initial begin
    drive_idle;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    test_reset;
    test_ready_dispatch;
    test_wakeup;
    test_bypass;
    test_priority_full;
    test_dual_cdb;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
